// File: rtl/freq_pkg.sv
// Shared definitions for the gated frequency counter: default widths and
// the controller state encoding.
package freq_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int GATE_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// The outputs are the values the registers take at the next clock edge.
// The controller captures the result in the same edge that finishes the
// gate window, so the final-cycle edge is included without an extra cycle.
module sat_counter
    import freq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_value_nxt,
    output logic         o_overflow_nxt
);

    logic [W-1:0] r_value;
    logic         r_overflow;
    logic         w_sat;

    assign w_sat = &r_value;

    // Next-state: clear wins, otherwise count up or flag an increment at all-ones
    always_comb begin
        o_value_nxt    = r_value;
        o_overflow_nxt = r_overflow;
        if (i_clr) begin
            o_value_nxt    = '0;
            o_overflow_nxt = 1'b0;
        end else if (i_inc) begin
            if (w_sat) begin
                o_overflow_nxt = 1'b1;
            end else begin
                o_value_nxt = r_value + W'(1);
            end
        end
    end

    // Working count and sticky flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_value    <= o_value_nxt;
            r_overflow <= o_overflow_nxt;
        end
    end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gated edge counter controller.
// Protocol: start is a one-cycle request honoured only while idle; the
// result is presented with a one-cycle done strobe, and count/overflow/
// no_signal then hold until the next done. abort or reset while busy drops
// the measurement silently. dbg_state exposes the controller state.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              pos_edge,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              no_signal,
    output state_t            dbg_state
);

    state_t              r_state;
    logic [GATE_W-1:0]   r_len;
    logic [GATE_W-1:0]   r_timer;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_no_signal;

    logic                w_clr;
    logic                w_inc;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_ovf_nxt;
    logic                w_timer_last;

    // Counter is cleared on every accepted start; only gate-window edges count,
    // and an abort in the same cycle suppresses the edge.
    assign w_clr        = (r_state == ST_IDLE) && start;
    assign w_inc        = (r_state == ST_GATE) && pos_edge && !abort;
    assign w_timer_last = (r_timer == GATE_W'(1));

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (w_clr),
        .i_inc          (w_inc),
        .o_value_nxt    (w_cnt_nxt),
        .o_overflow_nxt (w_ovf_nxt)
    );

    // Controller FSM with registered outputs; results load only on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_no_signal <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= gate_len;
                        r_timer <= gate_len;
                        if (gate_len == '0) begin
                            // Empty window: report immediately as no signal
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_count     <= w_cnt_nxt;
                            r_overflow  <= w_ovf_nxt;
                            r_no_signal <= 1'b1;
                        end else begin
                            r_state <= ST_SYNC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (pos_edge) begin
                        // Reference edge: not counted, opens the gate window
                        r_state <= ST_GATE;
                        r_timer <= r_len;
                    end else if (w_timer_last) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_count     <= w_cnt_nxt;
                        r_overflow  <= w_ovf_nxt;
                        r_no_signal <= 1'b1;
                    end else begin
                        r_timer <= r_timer - GATE_W'(1);
                    end
                end
                ST_GATE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_timer_last) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_count     <= w_cnt_nxt;
                        r_overflow  <= w_ovf_nxt;
                        r_no_signal <= 1'b0;
                    end else begin
                        r_timer <= r_timer - GATE_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign no_signal = r_no_signal;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: two instances (6-bit and 4-bit counters) share
// one stimulus stream. Each scenario is a table of per-cycle inputs; the
// expected outputs are derived from it by scanning measurement windows.
module tb_freq_gate_ctrl;
    import freq_pkg::*;

    localparam int GW   = 8;
    localparam int WA   = 6;
    localparam int WB   = 4;
    localparam int MAXN = 800;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pos_edge = 1'b0;
    logic [GW-1:0] gate_len = '0;

    logic          a_busy, a_done, a_ovf, a_nos;
    logic [WA-1:0] a_count;
    state_t        a_state;
    logic          b_busy, b_done, b_ovf, b_nos;
    logic [WB-1:0] b_count;
    state_t        b_state;

    always #5 clk = ~clk;

    freq_gate_ctrl #(.CNT_W(WA), .GATE_W(GW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .pos_edge(pos_edge), .busy(a_busy), .done(a_done),
        .count(a_count), .overflow(a_ovf), .no_signal(a_nos), .dbg_state(a_state)
    );

    freq_gate_ctrl #(.CNT_W(WB), .GATE_W(GW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .pos_edge(pos_edge), .busy(b_busy), .done(b_done),
        .count(b_count), .overflow(b_ovf), .no_signal(b_nos), .dbg_state(b_state)
    );

    // ---------------- stimulus tables and model ----------------
    bit     rn [MAXN];
    bit     st [MAXN];
    bit     ab [MAXN];
    bit     pe [MAXN];
    int     gl [MAXN];

    bit     e_busy [MAXN+1];
    bit     e_done [MAXN+1];
    state_t e_state[MAXN+1];
    bit     ev_set [MAXN+1];
    int     ev_raw [MAXN+1];
    int     ev_nos [MAXN+1];
    int     x_raw  [MAXN+1];
    int     x_nos  [MAXN+1];

    int held_raw = 0;
    int held_nos = 0;
    int n_vec = 0;
    int n_err = 0;
    int scen = 0;
    int cur_t = 0;
    logic [15:0] exp_q[$];

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (scenario %0d, cycle %0d): got %0d, expected %0d",
                     name, scen, cur_t, act, exp);
        end
    endtask

    task automatic clear_stim(input int n);
        for (int i = 0; i < MAXN; i++) begin
            rn[i] = 1'b1; st[i] = 1'b0; ab[i] = 1'b0; pe[i] = 1'b0;
            gl[i] = $urandom_range(0, 255);
        end
    endtask

    task automatic mark_done(input int e, input int raw, input int nos);
        e_done[e] = 1'b1;
        e_busy[e] = 1'b0;
        e_state[e] = ST_DONE;
        ev_set[e] = 1'b1;
        ev_raw[e] = raw;
        ev_nos[e] = nos;
        exp_q.push_back(16'(raw));
    endtask

    // A start accepted in cycle s with window L: SYNC occupies up to L cycles
    // waiting for a reference edge, then L gate cycles count edges, then one
    // DONE cycle. Abort or reset in any busy cycle drops the measurement.
    task automatic build_model(input int n);
        int  t, s, len, rf, c, edges;
        bit  cancelled;
        for (int i = 0; i <= n; i++) begin
            e_busy[i] = 1'b0; e_done[i] = 1'b0; e_state[i] = ST_IDLE;
            ev_set[i] = 1'b0; ev_raw[i] = 0; ev_nos[i] = 0;
        end
        t = 0;
        while (t < n) begin
            if (!(rn[t] && st[t])) begin
                t++;
                continue;
            end
            s = t;
            len = gl[t];
            if (len == 0) begin
                mark_done(s + 1, 0, 1);
                t = s + 2;
                continue;
            end
            rf = -1;
            cancelled = 1'b0;
            c = s;
            for (int k = 1; k <= len; k++) begin
                c = s + k;
                e_busy[c] = 1'b1;
                e_state[c] = ST_SYNC;
                if (!rn[c] || ab[c]) begin cancelled = 1'b1; break; end
                if (pe[c]) begin rf = c; break; end
            end
            if (cancelled) begin t = c + 1; continue; end
            if (rf < 0) begin
                mark_done(s + len + 1, 0, 1);
                t = s + len + 2;
                continue;
            end
            edges = 0;
            for (int k = 1; k <= len; k++) begin
                c = rf + k;
                e_busy[c] = 1'b1;
                e_state[c] = ST_GATE;
                if (!rn[c] || ab[c]) begin cancelled = 1'b1; break; end
                if (pe[c]) edges++;
            end
            if (cancelled) begin t = c + 1; continue; end
            mark_done(rf + len + 1, edges, 0);
            t = rf + len + 2;
        end
        // Held result values: reset clears them, a done replaces them
        for (int i = 1; i <= n; i++) begin
            if (!rn[i-1]) begin
                held_raw = 0;
                held_nos = 0;
            end else if (ev_set[i]) begin
                held_raw = ev_raw[i];
                held_nos = ev_nos[i];
            end
            x_raw[i] = held_raw;
            x_nos[i] = held_nos;
        end
    endtask

    // ---------------- compare (scoreboard) ----------------
    task automatic compare(input int t);
        logic [15:0] q;
        cur_t = t;
        check("a_busy", a_busy, e_busy[t]);
        check("a_done", a_done, e_done[t]);
        check("a_state", a_state, e_state[t]);
        check("a_count", a_count, sat(x_raw[t], WA));
        check("a_overflow", a_ovf, (x_raw[t] > sat(x_raw[t], WA)) ? 1 : 0);
        check("a_no_signal", a_nos, x_nos[t]);
        check("b_busy", b_busy, e_busy[t]);
        check("b_done", b_done, e_done[t]);
        check("b_state", b_state, e_state[t]);
        check("b_count", b_count, sat(x_raw[t], WB));
        check("b_overflow", b_ovf, (x_raw[t] > sat(x_raw[t], WB)) ? 1 : 0);
        check("b_no_signal", b_nos, x_nos[t]);
        if (a_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_done", 1, 0);
            end else begin
                q = exp_q.pop_front();
                check("sb_done_count", a_count, sat(int'(q), WA));
            end
        end
    endtask

    task automatic run_scenario(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (t > 0) compare(t);
            rst_n    = rn[t];
            start    = st[t];
            abort    = ab[t];
            pos_edge = pe[t];
            gate_len = GW'(gl[t]);
        end
        @(negedge clk);
        compare(n);
        scen++;
    endtask

    function automatic int first_done(input int n);
        for (int i = 0; i <= n; i++) if (e_done[i]) return i;
        return -1;
    endfunction

    function automatic int num_done(input int n);
        int c;
        c = 0;
        for (int i = 0; i <= n; i++) if (e_done[i]) c++;
        return c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int d, dens;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_count", a_count, 0);
        check("rst_a_overflow", a_ovf, 0);
        check("rst_a_no_signal", a_nos, 0);
        check("rst_a_state", a_state, ST_IDLE);
        check("rst_b_count", b_count, 0);

        // Edges every 4 cycles, window 100 -> 25 edges
        clear_stim(400);
        rn[0] = 1'b0; rn[1] = 1'b0;
        st[3] = 1'b1; gl[3] = 100;
        for (int i = 0; i < 400; i++) pe[i] = (i % 4 == 0);
        build_model(400);
        d = first_done(400);
        check("pin_every4_count", (d >= 0) ? ev_raw[d] : -1, 25);
        check("pin_every4_nosig", (d >= 0) ? ev_nos[d] : -1, 0);
        run_scenario(400);

        // No edges, window 50 -> done 51 cycles after the start cycle
        clear_stim(400);
        st[2] = 1'b1; gl[2] = 50;
        build_model(400);
        d = first_done(400);
        check("pin_timeout_cycle", d, 2 + 51);
        check("pin_timeout_nosig", (d >= 0) ? ev_nos[d] : -1, 1);
        run_scenario(400);

        // Edge every cycle, window 40 -> 40 edges, 4-bit view saturates
        clear_stim(400);
        st[2] = 1'b1; gl[2] = 40;
        for (int i = 0; i < 400; i++) pe[i] = 1'b1;
        build_model(400);
        d = first_done(400);
        check("pin_sat_raw", (d >= 0) ? ev_raw[d] : -1, 40);
        check("pin_sat_count4", sat((d >= 0) ? ev_raw[d] : 0, WB), 15);
        run_scenario(400);

        // Abort in gate cycle 10 with extra starts while busy -> no done
        clear_stim(400);
        st[2] = 1'b1; gl[2] = 60;
        for (int i = 0; i < 400; i++) pe[i] = (i % 3 == 0);
        ab[13] = 1'b1;
        st[5] = 1'b1; st[10] = 1'b1;
        build_model(400);
        check("pin_abort_dones", num_done(400), 0);
        check("pin_abort_busy13", e_busy[13], 1);
        check("pin_abort_idle14", e_state[14], ST_IDLE);
        run_scenario(400);

        // Reset in gate cycle 5, then a fresh 20-cycle measurement
        clear_stim(400);
        st[2] = 1'b1; gl[2] = 30;
        for (int i = 0; i < 400; i++) pe[i] = (i % 2 == 0);
        rn[9] = 1'b0;
        st[20] = 1'b1; gl[20] = 20;
        build_model(400);
        d = first_done(400);
        check("pin_reset_dones", num_done(400), 1);
        check("pin_reset_count", (d >= 0) ? ev_raw[d] : -1, 10);
        check("pin_reset_busy10", e_busy[10], 0);
        run_scenario(400);

        // Zero-length window -> done next cycle with no_signal
        clear_stim(400);
        st[2] = 1'b1; gl[2] = 0;
        for (int i = 0; i < 400; i++) pe[i] = ($urandom_range(0, 1) == 1);
        build_model(400);
        d = first_done(400);
        check("pin_zero_cycle", d, 3);
        check("pin_zero_nosig", (d >= 0) ? ev_nos[d] : -1, 1);
        run_scenario(400);

        // Randomized traffic
        for (int r = 0; r < 20; r++) begin
            clear_stim(560);
            dens = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(5, 100);
            for (int i = 0; i < 560; i++) begin
                pe[i] = ($urandom_range(0, 99) < dens);
                ab[i] = ($urandom_range(0, 199) == 0);
                if (i < 300) begin
                    st[i] = ($urandom_range(0, 24) == 0);
                    rn[i] = ($urandom_range(0, 399) != 0);
                    gl[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3)
                                                        : $urandom_range(1, 120);
                end
            end
            build_model(560);
            run_scenario(560);
        end

        cur_t = 0;
        check("sb_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
